// File: rtl/irq_request_ctrl.sv
// irq_request_ctrl
//   Request front-end for the 8-to-3 priority encoder stage. Rising edges on
//   the request lines are latched into a pending register. The highest-index
//   pending line whose enable bit is set is presented to the consumer over a
//   valid/ack handshake. The serviced pending bit is cleared on ack.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   req_in     level request lines, synchronous to clk
//   mask_in    enable mask value (1 = line enabled)
//   mask_we    load mask_in into the mask register on the next edge
//   irq_ack    consumer acknowledge; ignored unless irq_valid is high
//   irq_valid  a selected request is being presented
//   irq_id     index of the presented request
//   pending    current pending register
//   mask       current mask register
//
// State | meaning
// IDLE  | nothing presented; select from pending & mask
// BUSY  | irq_id presented and held until acknowledged
module irq_request_ctrl #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic [N-1:0] mask_in,
    input  logic         mask_we,
    input  logic         irq_ack,
    output logic         irq_valid,
    output logic [W-1:0] irq_id,
    output logic [N-1:0] pending,
    output logic [N-1:0] mask
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   req_prev_q;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   mask_q, mask_d;
    logic [W-1:0]   irq_id_q, irq_id_d;
    logic           irq_valid_q, irq_valid_d;

    logic [N-1:0]   req_edge;
    logic [N-1:0]   clr;
    logic [N-1:0]   sel;
    logic [W-1:0]   sel_id;

    assign req_edge = req_in & ~req_prev_q;
    assign sel      = pending_q & mask_q;

    // Highest index wins: later iterations overwrite earlier ones.
    always_comb begin
        sel_id = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                sel_id = W'(i);
            end
        end
    end

    // Set wins over clear so an edge arriving with the ack is not lost.
    always_comb begin
        clr = '0;
        if (state_q == BUSY && irq_ack) begin
            clr[irq_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | req_edge;
    end

    assign mask_d = mask_we ? mask_in : mask_q;

    always_comb begin
        state_d     = state_q;
        irq_id_d    = irq_id_q;
        irq_valid_d = irq_valid_q;
        unique case (state_q)
            IDLE: begin
                irq_valid_d = 1'b0;
                if (sel != '0) begin
                    irq_id_d    = sel_id;
                    irq_valid_d = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // No preemption: irq_id holds until the consumer acks.
                if (irq_ack) begin
                    irq_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                irq_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_prev_q  <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            irq_id_q    <= '0;
            irq_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_prev_q  <= req_in;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            irq_id_q    <= irq_id_d;
            irq_valid_q <= irq_valid_d;
        end
    end

    assign irq_valid = irq_valid_q;
    assign irq_id    = irq_id_q;
    assign pending   = pending_q;
    assign mask      = mask_q;

endmodule

// File: tb/tb_irq_request_ctrl.sv
module tb_irq_request_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_in = '0;
    logic [7:0] mask_in = '0;
    logic       mask_we = 1'b0;
    logic       irq_ack = 1'b0;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] pending;
    logic [7:0] mask;

    int vectors = 0;
    int errors  = 0;
    int exp_q[$];

    irq_request_ctrl #(.N(8), .W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .mask_in   (mask_in),
        .mask_we   (mask_we),
        .irq_ack   (irq_ack),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .pending   (pending),
        .mask      (mask)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge: drive and sample here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a grant and compare it against the scoreboard head.
    task automatic wait_grant(input string tag);
        int n;
        int exp_id;
        n = 0;
        while (irq_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, irq_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp_id = exp_q.pop_front();
            chk({tag, "_id"}, {29'd0, irq_id}, exp_id);
        end
    endtask

    // Acknowledge for one cycle; valid must drop immediately after (bubble).
    task automatic do_ack(input string tag);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk({tag, "_bubble"}, {31'd0, irq_valid}, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid",   {31'd0, irq_valid}, 32'd0);
        chk("rst_pending", {24'd0, pending}, 32'h00);
        chk("rst_mask",    {24'd0, mask}, 32'h00);
        chk("rst_id",      {29'd0, irq_id}, 32'd0);
        rst = 1'b0;
        tick();

        // Single pulse, latency check.
        mask_in = 8'hFF;
        mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
        chk("t1_mask", {24'd0, mask}, 32'hFF);
        req_in = 8'b0000_0100;
        exp_q.push_back(2);
        tick();
        req_in = 8'h00;
        chk("t1_pending", {24'd0, pending}, 32'h04);
        chk("t1_valid_early", {31'd0, irq_valid}, 32'd0);
        tick();
        chk("t1_valid_lat", {31'd0, irq_valid}, 32'd1);
        wait_grant("t1");
        do_ack("t1");
        chk("t1_pending_clr", {24'd0, pending}, 32'h00);

        // Held multi-bit level: served in priority order, no re-trigger.
        req_in = 8'b0101_1011;
        exp_q.push_back(6);
        exp_q.push_back(4);
        exp_q.push_back(3);
        exp_q.push_back(1);
        exp_q.push_back(0);
        for (int k = 0; k < 5; k++) begin
            wait_grant("t2");
            do_ack("t2");
        end
        tick();
        tick();
        tick();
        chk("t2_no_retrig_valid", {31'd0, irq_valid}, 32'd0);
        chk("t2_no_retrig_pend",  {24'd0, pending}, 32'h00);
        req_in = 8'h00;
        tick();

        // Masked pending bits retained, presented once enabled.
        mask_in = 8'h0F;
        mask_we = 1'b1;
        req_in  = 8'hF0;
        tick();
        mask_we = 1'b0;
        req_in  = 8'h00;
        tick();
        tick();
        tick();
        chk("t3_masked_valid", {31'd0, irq_valid}, 32'd0);
        chk("t3_masked_pend",  {24'd0, pending}, 32'hF0);
        chk("t3_mask",         {24'd0, mask}, 32'h0F);
        mask_in = 8'hFF;
        mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
        exp_q.push_back(7);
        exp_q.push_back(6);
        exp_q.push_back(5);
        exp_q.push_back(4);
        for (int k = 0; k < 4; k++) begin
            wait_grant("t3");
            do_ack("t3");
        end

        // No preemption by a higher-priority arrival.
        req_in = 8'h04;
        exp_q.push_back(2);
        tick();
        req_in = 8'h00;
        wait_grant("t4_first");
        req_in = 8'h80;
        tick();
        req_in = 8'h00;
        tick();
        tick();
        tick();
        chk("t4_hold_valid", {31'd0, irq_valid}, 32'd1);
        chk("t4_hold_id",    {29'd0, irq_id}, 32'd2);
        chk("t4_pending",    {24'd0, pending}, 32'h84);
        exp_q.push_back(7);
        do_ack("t4_first");
        wait_grant("t4_second");
        do_ack("t4_second");
        chk("t4_pending_clr", {24'd0, pending}, 32'h00);

        // Edge coinciding with ack on the same bit: set wins.
        req_in = 8'h20;
        exp_q.push_back(5);
        tick();
        req_in = 8'h00;
        wait_grant("t5_first");
        req_in  = 8'h20;
        irq_ack = 1'b1;
        tick();
        req_in  = 8'h00;
        irq_ack = 1'b0;
        chk("t5_setwins_pend",  {24'd0, pending}, 32'h20);
        chk("t5_setwins_valid", {31'd0, irq_valid}, 32'd0);
        exp_q.push_back(5);
        wait_grant("t5_second");
        do_ack("t5_second");

        // Reset mid-handshake, request held through release.
        req_in = 8'h81;
        exp_q.push_back(7);
        tick();
        wait_grant("t6");
        chk("t6_pending_pre", {24'd0, pending}, 32'h81);
        req_in = 8'h01;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", {31'd0, irq_valid}, 32'd0);
        chk("t6_async_pend",  {24'd0, pending}, 32'h00);
        chk("t6_async_mask",  {24'd0, mask}, 32'h00);
        tick();
        tick();
        rst = 1'b0;
        chk("t6_release_pend", {24'd0, pending}, 32'h00);
        tick();
        chk("t6_first_edge_pend", {24'd0, pending}, 32'h01);
        tick();
        chk("t6_masked_after_rst", {31'd0, irq_valid}, 32'd0);
        req_in = 8'h00;
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
